// File: rtl/oven_timer_pkg.sv
// Shared types and constants for the oven cook-time counter.
// Consumed by oven_timer and oven_prescaler.
package oven_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SEC30  = 30;
  localparam int SEC60  = 60;
  localparam int SEC120 = 120;

  // Longest selection wins; no valid selection means a zero-length cook.
  function automatic logic [7:0] sel_seconds(input logic s30, input logic s60,
                                             input logic s120, input logic time_set);
    logic [7:0] v;
    v = 8'd0;
    if (time_set) begin
      if (s120)     v = 8'(SEC120);
      else if (s60) v = 8'(SEC60);
      else if (s30) v = 8'(SEC30);
    end
    return v;
  endfunction

endpackage

// File: rtl/oven_prescaler.sv
// Divides the clock into one-second ticks: tick pulses on every
// TICKS_PER_SEC-th enabled cycle; clr restarts the second, en=0 holds it.
module oven_prescaler #(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(TICKS_PER_SEC - 1));
  assign tick   = en && w_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/oven_timer.sv
// Cook-time counter for the oven controller: loads the selected duration on
// start, counts it down in seconds, pauses on stop and pulses timeout on expiry.
// Optional beep output is enabled with `define OVEN_TIMER_BEEP_EN.
module oven_timer
  import oven_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int SEC_W         = 7
`ifdef OVEN_TIMER_BEEP_EN
  ,
  parameter int BEEP_CYCLES   = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_count,
  input  logic             stop_count,
  input  logic             s30,
  input  logic             s60,
  input  logic             s120,
  input  logic             time_set,
  output logic             timeout,
  output logic             running,
  output logic [SEC_W-1:0] remaining
`ifdef OVEN_TIMER_BEEP_EN
  ,
  output logic             beep
`endif
);

  state_t           r_state;
  logic             r_timeout;
  logic             r_running;
  logic [SEC_W-1:0] r_remaining;

  logic [SEC_W-1:0] w_sel;
  logic             w_go;
  logic             w_tick;
  logic             w_count_en;
  logic             w_load;
  logic             w_expire;

  assign w_sel      = SEC_W'(sel_seconds(s30, s60, s120, time_set));
  assign w_go       = start_count && !stop_count;
  assign w_count_en = (r_state == RUN) && !stop_count;
  assign w_load     = (r_state == IDLE) && w_go && (w_sel != '0);
  // Treating remaining<=1 as the last second keeps the count from wrapping.
  assign w_expire   = w_count_en && w_tick && (r_remaining <= SEC_W'(1));

  oven_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (w_count_en),
    .clr  (r_state == IDLE),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_timeout   <= 1'b0;
      r_running   <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_remaining <= w_sel;
            r_state     <= RUN;
            r_running   <= 1'b1;
          end
        end
        RUN: begin
          if (stop_count) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
          end else if (w_expire) begin
            r_remaining <= '0;
            r_timeout   <= 1'b1;
            r_state     <= DONE;
            r_running   <= 1'b0;
          end else if (w_tick) begin
            r_remaining <= r_remaining - 1'b1;
          end
        end
        PAUSE: begin
          if (w_go) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        DONE: begin
          // A start still held from the previous run must not retrigger.
          if (!start_count) r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign timeout   = r_timeout;
  assign running   = r_running;
  assign remaining = r_remaining;

`ifdef OVEN_TIMER_BEEP_EN
  localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

  logic [BEEP_W-1:0] r_beep_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beep_cnt <= '0;
    end else if (w_load) begin
      r_beep_cnt <= '0;
    end else if (w_expire) begin
      r_beep_cnt <= BEEP_W'(BEEP_CYCLES);
    end else if (r_beep_cnt != '0) begin
      r_beep_cnt <= r_beep_cnt - 1'b1;
    end
  end

  assign beep = (r_beep_cnt != '0);
`endif

endmodule

// File: tb/tb_oven_timer.sv
// Self-checking bench for oven_timer: two instances (1 and 4 clocks per second)
// share directed and random stimulus and are compared against a cycle-budget model.
module tb_oven_timer;

  localparam int NI   = 2;
  localparam int BEEP = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_count = 1'b0, stop_count = 1'b0;
  logic s30 = 1'b0, s60 = 1'b0, s120 = 1'b0, time_set = 1'b0;

  logic [NI-1:0]      to_o;
  logic [NI-1:0]      run_o;
  logic [NI-1:0][6:0] rem_o;
`ifdef OVEN_TIMER_BEEP_EN
  logic [NI-1:0]      beep_o;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Model: a run is a budget of active clock cycles; seconds left is derived from it.
  int tk [NI] = '{1, 4};
  int m_st   [NI];   // 0 idle, 1 counting, 2 paused, 3 done
  int m_left [NI];
  int m_to   [NI];
  int m_beep [NI];

  always #5 clk = ~clk;

  oven_timer #(.TICKS_PER_SEC(1), .SEC_W(7)) dut (
    .clk(clk), .reset(reset), .start_count(start_count), .stop_count(stop_count),
    .s30(s30), .s60(s60), .s120(s120), .time_set(time_set),
    .timeout(to_o[0]), .running(run_o[0]), .remaining(rem_o[0])
`ifdef OVEN_TIMER_BEEP_EN
    , .beep(beep_o[0])
`endif
  );

  oven_timer #(.TICKS_PER_SEC(4), .SEC_W(7)) dut4 (
    .clk(clk), .reset(reset), .start_count(start_count), .stop_count(stop_count),
    .s30(s30), .s60(s60), .s120(s120), .time_set(time_set),
    .timeout(to_o[1]), .running(run_o[1]), .remaining(rem_o[1])
`ifdef OVEN_TIMER_BEEP_EN
    , .beep(beep_o[1])
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int sel;
    bit go;
    if (!reset) begin
      m_st[k] = 0; m_left[k] = 0; m_to[k] = 0; m_beep[k] = 0;
      return;
    end
    sel = !time_set ? 0 : s120 ? 120 : s60 ? 60 : s30 ? 30 : 0;
    go  = start_count && !stop_count;
    m_to[k] = 0;
    if (m_beep[k] > 0) m_beep[k]--;
    case (m_st[k])
      0: if (go && sel != 0) begin
           m_st[k] = 1; m_left[k] = sel * tk[k]; m_beep[k] = 0;
         end
      1: if (stop_count) m_st[k] = 2;
         else begin
           m_left[k]--;
           if (m_left[k] == 0) begin
             m_st[k] = 3; m_to[k] = 1; m_beep[k] = BEEP;
           end
         end
      2: if (go) m_st[k] = 1;
      default: if (!start_count) m_st[k] = 0;
    endcase
  endtask

  // Inputs are already set; advance one clock and compare at the falling edge.
  task automatic cycle();
    for (int k = 0; k < NI; k++) model_step(k);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("timeout[%0d]", k), int'(to_o[k]), m_to[k]);
      chk($sformatf("running[%0d]", k), int'(run_o[k]), int'(m_st[k] == 1));
      chk($sformatf("remaining[%0d]", k), int'(rem_o[k]), (m_left[k] + tk[k] - 1) / tk[k]);
`ifdef OVEN_TIMER_BEEP_EN
      chk($sformatf("beep[%0d]", k), int'(beep_o[k]), int'(m_beep[k] > 0));
`endif
    end
  endtask

  task automatic set_sel(input logic a30, input logic a60, input logic a120, input logic ts);
    s30 = a30; s60 = a60; s120 = a120; time_set = ts;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    start_count = 1'b0; stop_count = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_timeout[%0d]", tag, k), int'(to_o[k]), 0);
      chk($sformatf("%s_running[%0d]", tag, k), int'(run_o[k]), 0);
      chk($sformatf("%s_remaining[%0d]", tag, k), int'(rem_o[k]), 0);
    end
    cycle();
    reset = 1'b1;
  endtask

  task automatic wait_to(input int k, input int maxc, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!to_o[k] && n < maxc);
  endtask

  initial begin
    int n, pulses;

    // 1: s30 run, timeout exactly 30 cycles after the sampling edge
    do_reset("rst0");
    set_sel(1, 0, 0, 1);
    start_count = 1'b1;
    cycle();
    chk("t1_running", int'(run_o[0]), 1);
    chk("t1_remaining", int'(rem_o[0]), 30);
    start_count = 1'b0;
    wait_to(0, 100, n);
    chk("t1_latency", n, 30);
    chk("t1_rem_end", int'(rem_o[0]), 0);
    $display("tx t1 s30 latency=%0d", n);

    // 2: s60 with a 10-cycle pause after 10 seconds
    do_reset("rst2");
    set_sel(0, 1, 0, 1);
    start_count = 1'b1;
    cycle();
    start_count = 1'b0;
    set_sel(0, 0, 0, 0);
    repeat (10) cycle();
    stop_count = 1'b1;
    start_count = 1'b1;
    repeat (10) cycle();
    chk("t2_paused_rem", int'(rem_o[0]), 50);
    chk("t2_paused_run", int'(run_o[0]), 0);
    stop_count = 1'b0;
    cycle();
    start_count = 1'b0;
    wait_to(0, 200, n);
    chk("t2_resume_latency", n, 50);
    $display("tx t2 resume latency=%0d", n);

    // 3: no valid selection -> start is ignored; then s30&s120 gives 120
    do_reset("rst3");
    set_sel(1, 1, 1, 0);
    start_count = 1'b1;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      pulses += int'(to_o[0]);
    end
    chk("t3_no_run", int'(run_o[0]), 0);
    chk("t3_no_timeout", pulses, 0);
    start_count = 1'b0;
    cycle();
    set_sel(1, 0, 1, 1);
    start_count = 1'b1;
    cycle();
    start_count = 1'b0;
    wait_to(0, 300, n);
    chk("t3_s120_latency", n, 120);
    $display("tx t3 s30+s120 latency=%0d", n);

    // 4: start held through expiry -> one pulse; release and press restarts
    do_reset("rst4");
    set_sel(1, 0, 0, 1);
    start_count = 1'b1;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      pulses += int'(to_o[0]);
    end
    chk("t4_one_pulse", pulses, 1);
    start_count = 1'b0;
    cycle();
    start_count = 1'b1;
    cycle();
    chk("t4_rerun", int'(run_o[0]), 1);
    $display("tx t4 held-start pulses=%0d", pulses);

    // 5: reset in the middle of an s120 run
    do_reset("rst5a");
    set_sel(0, 0, 1, 1);
    start_count = 1'b1;
    cycle();
    start_count = 1'b0;
    n = 0;
    while (rem_o[0] != 7'd40 && n < 200) begin
      cycle();
      n++;
    end
    chk("t5_reach40", int'(rem_o[0]), 40);
    do_reset("rst5b");
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      cycle();
      pulses += int'(to_o[0]) + int'(to_o[1]);
    end
    chk("t5_no_timeout", pulses, 0);
    $display("tx t5 post-reset pulses=%0d", pulses);

    // 6: four clocks per second, s30 -> 120 cycles
    do_reset("rst6");
    set_sel(1, 0, 0, 1);
    start_count = 1'b1;
    cycle();
    start_count = 1'b0;
    wait_to(1, 600, n);
    chk("t6_tps4_latency", n, 120);
    repeat (8) cycle();
    $display("tx t6 tps4 latency=%0d", n);

    // Random traffic against the model
    do_reset("rst7");
    for (int i = 0; i < 4000; i++) begin
      start_count = ($urandom_range(3) == 0);
      stop_count  = ($urandom_range(15) == 0);
      if ($urandom_range(19) == 0)
        set_sel(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(7) != 0));
      cycle();
    end
    $display("tx random done");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
